// File: rtl/branch_predictor_table.sv
// branch_predictor_table: bimodal/gshare table of saturating counters with init sweep
// Ports: clk, reset (async, active-high); mode (0 bimodal, 1 gshare); flush (reinit);
//   ready (table in RUN); lookup_valid/lookup_pc -> pred_valid/pred_taken/pred_idx (1-cycle latency);
//   upd_valid/upd_idx/upd_taken/upd_mispredict (resolved branch); mispredict_count (saturating).
module branch_predictor_table #(
  parameter int IDX_W  = 6,
  parameter int CTR_W  = 2,
  parameter int GHR_W  = 6,
  parameter int PC_LSB = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             flush,
  output logic             ready,
  input  logic             lookup_valid,
  input  logic [31:0]      lookup_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_mispredict,
  output logic [15:0]      mispredict_count
);
  localparam logic [CTR_W-1:0] INIT_V = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] MAX_V  = '1;
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [15:0] mcnt_q, mcnt_d;
  logic pred_valid_q, pred_valid_d, pred_taken_q, pred_taken_d;
  logic [IDX_W-1:0] pred_idx_q, pred_idx_d;
  logic [CTR_W-1:0] ctr_q [2**IDX_W];
  logic [IDX_W-1:0] lk_idx, waddr;
  logic [CTR_W-1:0] upd_cur, upd_ctr, wdata;
  logic we, unused_pc;
  assign unused_pc = ^lookup_pc;
  assign lk_idx = lookup_pc[PC_LSB+IDX_W-1:PC_LSB] ^ (mode ? IDX_W'(ghr_q) : '0);
  assign upd_cur = ctr_q[upd_idx];
  assign upd_ctr = upd_taken ? (upd_cur == MAX_V ? upd_cur : upd_cur + 1'b1)
                             : (upd_cur == '0 ? upd_cur : upd_cur - 1'b1);
  // single write port: the sweep owns it in INIT, updates own it in RUN; flush suppresses both
  assign we = !flush && (state_q == INIT || upd_valid);
  assign waddr = state_q == INIT ? sweep_q : upd_idx;
  assign wdata = state_q == INIT ? INIT_V : upd_ctr;
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    ghr_d = ghr_q;
    mcnt_d = mcnt_q;
    pred_valid_d = 1'b0;
    pred_taken_d = pred_taken_q;
    pred_idx_d = pred_idx_q;
    if (flush) begin
      state_d = INIT;
      sweep_d = '0;
      ghr_d = '0;
      mcnt_d = '0;
    end else if (state_q == INIT) begin
      sweep_d = sweep_q + 1'b1;
      state_d = sweep_q == '1 ? RUN : INIT;
    end else begin
      if (lookup_valid) begin
        pred_valid_d = 1'b1;
        pred_taken_d = ctr_q[lk_idx][CTR_W-1];
        pred_idx_d = lk_idx;
      end
      if (upd_valid) begin
        ghr_d = {ghr_q[GHR_W-2:0], upd_taken};
        mcnt_d = mcnt_q + 16'(upd_mispredict && mcnt_q != 16'hFFFF);
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      sweep_q <= '0;
      ghr_q <= '0;
      mcnt_q <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_idx_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ghr_q <= ghr_d;
      mcnt_q <= mcnt_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_idx_q <= pred_idx_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) ctr_q[waddr] <= wdata;
  end
  assign ready = state_q == RUN;
  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_idx = pred_idx_q;
  assign mispredict_count = mcnt_q;
endmodule

// File: tb/tb_branch_predictor_table.sv
// tb_branch_predictor_table: scoreboard bench with directed and random stimulus against an array model
module tb_branch_predictor_table;
  logic clk = 1'b0, reset = 1'b0, mode = 1'b0, flush = 1'b0;
  logic lookup_valid = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0, upd_mispredict = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic [5:0] upd_idx = '0;
  logic ready, pred_valid, pred_taken;
  logic [5:0] pred_idx;
  logic [15:0] mispredict_count;
  branch_predictor_table dut (
    .clk(clk), .reset(reset), .mode(mode), .flush(flush), .ready(ready),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_idx(pred_idx),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .mispredict_count(mispredict_count)
  );
  always #5 clk = ~clk;
  typedef struct {int due; bit taken; int idx;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0, cycn = 0;
  int ctr[64];
  int ghr = 0, mc = 0, icnt = 0;
  bit mready = 0;
  always @(posedge clk) cycn <= cycn + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h expected %0h", n, $time, act, exp);
    end
  endtask
  always @(negedge clk) if (!reset) begin
    if (pred_valid) begin
      checks++;
      if (q.size() == 0 || q[0].due != cycn) begin
        errors++;
        $display("FAIL pred_unexpected cyc=%0d got pred_valid=1 expected 0", cycn);
      end else begin
        e = q.pop_front();
        if (pred_taken !== e.taken || pred_idx !== 6'(e.idx)) begin
          errors++;
          $display("FAIL pred cyc=%0d got taken=%0b idx=%0d expected taken=%0b idx=%0d",
                   cycn, pred_taken, pred_idx, e.taken, e.idx);
        end
      end
    end else if (q.size() > 0 && q[0].due <= cycn) begin
      checks++;
      errors++;
      $display("FAIL pred_missing cyc=%0d got pred_valid=0 expected 1", cycn);
      void'(q.pop_front());
    end
  end
  task automatic model_init();
    mready = 0;
    icnt = 0;
    ghr = 0;
    mc = 0;
    foreach (ctr[i]) ctr[i] = 1;
  endtask
  task automatic cyc(input bit lv, input logic [31:0] pc, input bit uv, input int ui,
                     input bit ut, input bit um, input bit fl, input bit md);
    int idx;
    lookup_valid = lv; lookup_pc = pc; upd_valid = uv; upd_idx = 6'(ui);
    upd_taken = ut; upd_mispredict = um; flush = fl; mode = md;
    chk("ready", 32'(ready), 32'(mready));
    chk("mispredict_count", 32'(mispredict_count), 32'(mc));
    if (fl) model_init();
    else if (!mready) begin
      icnt++;
      if (icnt == 64) mready = 1;
    end else begin
      if (lv) begin
        idx = (pc >> 2) & 63;
        if (md) idx = idx ^ ghr;
        q.push_back('{cycn + 1, ctr[idx] >= 2, idx});
      end
      if (uv) begin
        ctr[ui] = ut ? (ctr[ui] == 3 ? 3 : ctr[ui] + 1) : (ctr[ui] == 0 ? 0 : ctr[ui] - 1);
        ghr = ((ghr << 1) | int'(ut)) & 63;
        if (um && mc < 65535) mc++;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    lookup_valid = 0; upd_valid = 0; flush = 0;
    reset = 1;
    #1;
    chk("rst_ready", 32'(ready), 0);
    chk("rst_pred_valid", 32'(pred_valid), 0);
    chk("rst_pred_taken", 32'(pred_taken), 0);
    chk("rst_pred_idx", 32'(pred_idx), 0);
    chk("rst_mcnt", 32'(mispredict_count), 0);
    q.delete();
    model_init();
    @(posedge clk);
    #1;
    reset = 0;
  endtask
  initial begin
    #2;
    do_reset();
    idle(63);
    chk("ready_before_64", 32'(ready), 0);
    idle(1);
    chk("ready_at_64", 32'(ready), 1);
    cyc(1, 32'h100, 0, 0, 0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 1, 1, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 0, 0, 0);
    cyc(1, 32'h104, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 0, 0, 0);
    cyc(1, 32'h104, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0, 0);
    cyc(1, 32'h104, 0, 0, 0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    idle(64);
    cyc(0, 0, 1, 5, 1, 0, 0, 1);
    cyc(0, 0, 1, 5, 1, 0, 0, 1);
    cyc(0, 0, 1, 5, 0, 0, 0, 1);
    cyc(1, 32'h104, 0, 0, 0, 0, 0, 1);
    idle(1);
    cyc(1, 32'h104, 1, 1, 1, 0, 0, 0);
    cyc(1, 32'h104, 0, 0, 0, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 10 + i, 1, 1, 0, 0);
    chk("mcnt_five", 32'(mispredict_count), 5);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    chk("flush_ready_low", 32'(ready), 0);
    chk("flush_mcnt", 32'(mispredict_count), 0);
    idle(64);
    for (int i = 0; i < 64; i++) cyc(1, 32'(i * 4), 0, 0, 0, 0, 0, 0);
    idle(1);
    do_reset();
    idle(30);
    do_reset();
    idle(63);
    chk("rst_mid_ready_low", 32'(ready), 0);
    idle(1);
    chk("rst_mid_ready_high", 32'(ready), 1);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      else cyc($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom_range(0, 7),
               $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 299) == 0,
               $urandom_range(0, 1));
    end
    idle(2);
    chk("queue_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predictor_table.md
BRANCH_PREDICTOR_TABLE -- requirements
Module: branch_predictor_table

Interface
REQ-001 Parameter IDX_W, default 6, SHALL set table depth to 2^IDX_W counters.
REQ-002 Parameter CTR_W, default 2, range 2..4, SHALL set the saturating counter width.
REQ-003 Parameter GHR_W, default 6, range 1..IDX_W, SHALL set the global history register width.
REQ-004 Parameter PC_LSB, default 2, SHALL set the lowest PC bit used for indexing.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 mode  input  1  0 = bimodal indexing, 1 = gshare indexing; sampled every cycle.
REQ-008 flush  input  1  synchronous single-cycle request to reinitialise the table and history.
REQ-009 ready  output  1  high when the table is in RUN and accepts lookups and updates.
REQ-010 lookup_valid  input  1  lookup request.
REQ-011 lookup_pc  input  32  branch PC to predict.
REQ-012 pred_valid  output  1  prediction result valid, one-cycle pulse.
REQ-013 pred_taken  output  1  predicted direction.
REQ-014 pred_idx  output  IDX_W  table index used for the prediction, returned later on upd_idx.
REQ-015 upd_valid  input  1  resolved-branch update.
REQ-016 upd_idx  input  IDX_W  index to update (the pred_idx of that branch).
REQ-017 upd_taken  input  1  actual outcome.
REQ-018 upd_mispredict  input  1  resolved branch was mispredicted.
REQ-019 mispredict_count  output  16  saturating count of accepted updates with upd_mispredict=1.

Function
REQ-020 FSM SHALL have two states: INIT (table sweep) and RUN; ready = (state == RUN), registered.
REQ-021 In INIT, a sweep counter SHALL write init value 2^(CTR_W-1)-1 (weakly not-taken) to one entry per cycle, index 0 upward; after writing entry 2^IDX_W-1 the FSM SHALL enter RUN, so ready rises exactly 2^IDX_W cycles after INIT entry.
REQ-022 In INIT, lookups and updates SHALL be ignored; pred_valid stays 0; GHR and mispredict_count hold 0.
REQ-023 flush in RUN SHALL enter INIT next cycle, sweep from 0, clear GHR and mispredict_count; flush in INIT SHALL restart the sweep at 0.
REQ-024 Index: bimodal = lookup_pc[PC_LSB+IDX_W-1:PC_LSB]; gshare = that field XOR GHR zero-extended to IDX_W.
REQ-025 A lookup accepted in cycle t (ready & lookup_valid) SHALL produce registered pred_valid=1, pred_taken = counter MSB, pred_idx in cycle t+1; otherwise pred_valid=0 and pred_taken/pred_idx hold.
REQ-026 An accepted update (ready & upd_valid) SHALL increment counter[upd_idx] when upd_taken=1, decrement when 0, saturating at 2^CTR_W-1 and 0.
REQ-027 An accepted update SHALL shift GHR left by one, inserting upd_taken at bit 0, discarding MSB.
REQ-028 Lookup and update in the same cycle: lookup SHALL use the pre-update counter and pre-update GHR (read-before-write).
REQ-029 mispredict_count SHALL increment on accepted updates with upd_mispredict=1 and hold at 16'hFFFF.
REQ-030 flush and a lookup/update in the same cycle: flush SHALL win; the lookup produces no pred_valid and the update is discarded.

Reset
REQ-031 reset SHALL asynchronously force: state INIT, sweep counter 0, GHR 0, ready 0, pred_valid 0, pred_taken 0, pred_idx 0, mispredict_count 0; the sweep starts on the first clock edge after reset deasserts.
REQ-032 reset asserted mid-sweep or in RUN SHALL abandon all in-flight work; no pred_valid after deassertion until a new lookup is accepted in RUN.

Verification
REQ-033 Reset release, defaults -> ready rises after exactly 64 cycles; first lookup pc=0x100 -> pred_valid next cycle, pred_taken=0, pred_idx=0.
REQ-034 Bimodal, pc=0x104 (idx 1): two taken updates on idx 1 -> lookup predicts taken (counter 3); third taken update -> counter stays 3; two not-taken -> predicts not-taken.
REQ-035 Gshare, after updates taken,taken,not-taken (GHR=6'b000110), lookup pc=0x104 -> pred_idx = 6'b000111.
REQ-036 Same-cycle lookup and taken update on idx 1 with counter 1 -> pred_taken=0 that cycle; next lookup -> pred_taken=1.
REQ-037 flush in RUN after 5 mispredicts -> ready low next cycle, mispredict_count=0, GHR=0, ready high 64 cycles later, all entries predict not-taken.
REQ-038 reset pulsed at sweep cycle 30 -> sweep restarts at 0, ready rises 64 cycles after deassertion.
